// File: rtl/prog_run_ctrl.sv
// Run controller: accepts a run request and selects the program bank.
// It then resets and starts the core, times the run with a watchdog,
// and returns the result through a valid/ready response port.
//
// state   | meaning
// IDLE    | waiting for a request, core held in reset
// RESET   | core_reset asserted for RST_CYCLES
// START   | core_start asserted for START_CYCLES
// RUN     | counting cycles until ack, abort or watchdog
// RESP    | result presented until the host accepts it
module prog_run_ctrl #(
  parameter int PROG_W       = 2,
  parameter int CNT_W        = 16,
  parameter int RST_CYCLES   = 2,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 4000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PROG_W-1:0] req_prog,
  input  logic              abort,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [PROG_W-1:0] resp_prog,
  output logic [CNT_W-1:0]  resp_cycles,
  output logic              resp_timeout,
  output logic              resp_abort,
  output logic [PROG_W-1:0] prog_sel,
  output logic              core_reset,
  output logic              core_start,
  input  logic              core_ack,
  output logic              busy
);

  localparam int PH_MAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  PH_RST   = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_START = PH_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  cnt;
  logic [PROG_W-1:0] prog_q;
  logic [CNT_W-1:0]  cycles_q;
  logic              timeout_q;
  logic              abort_q;

  logic              accept;
  logic              ld_start;
  logic              ph_dec;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              fin;
  logic [CNT_W-1:0]  fin_cycles;
  logic              fin_to;
  logic              fin_ab;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and datapath strobes; priority in RUN is abort > ack > timeout
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    ld_start   = 1'b0;
    ph_dec     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    fin        = 1'b0;
    fin_cycles = '0;
    fin_to     = 1'b0;
    fin_ab     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_RESET;
        end
      end
      S_RESET: begin
        if (abort) begin
          fin       = 1'b1;
          fin_ab    = 1'b1;
          state_nxt = S_RESP;
        end else if (phase == '0) begin
          ld_start  = 1'b1;
          state_nxt = S_START;
        end else begin
          ph_dec = 1'b1;
        end
      end
      S_START: begin
        if (abort) begin
          fin       = 1'b1;
          fin_ab    = 1'b1;
          state_nxt = S_RESP;
        end else if (phase == '0) begin
          cnt_clr   = 1'b1;
          state_nxt = S_RUN;
        end else begin
          ph_dec = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          fin        = 1'b1;
          fin_ab     = 1'b1;
          fin_cycles = cnt;
          state_nxt  = S_RESP;
        end else if (core_ack) begin
          fin        = 1'b1;
          fin_cycles = cnt;
          state_nxt  = S_RESP;
        end else if (cnt == TMO) begin
          fin        = 1'b1;
          fin_to     = 1'b1;
          fin_cycles = TMO;
          state_nxt  = S_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase down-counter, run counter, program latch and result registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      phase     <= '0;
      cnt       <= '0;
      prog_q    <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      if (accept) begin
        prog_q <= req_prog;
        phase  <= PH_RST;
      end else if (ld_start) begin
        phase <= PH_START;
      end else if (ph_dec) begin
        phase <= phase - PH_W'(1);
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (fin) begin
        cycles_q  <= fin_cycles;
        timeout_q <= fin_to;
        abort_q   <= fin_ab;
      end
    end
  end

  // The core keeps reset released in RESP so its Ack stays visible to the host
  assign req_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign core_reset   = (state == S_IDLE) || (state == S_RESET);
  assign core_start   = (state == S_START);
  assign resp_valid   = (state == S_RESP);
  assign prog_sel     = prog_q;
  assign resp_prog    = prog_q;
  assign resp_cycles  = cycles_q;
  assign resp_timeout = timeout_q;
  assign resp_abort   = abort_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: a table of run scenarios plus hand-written
// sequences for backpressure and reset in the middle of a run.
module tb_prog_run_ctrl;

  localparam int PROG_W  = 2;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 50;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req_valid;
  logic              req_ready;
  logic [PROG_W-1:0] req_prog;
  logic              abort;
  logic              resp_valid;
  logic              resp_ready;
  logic [PROG_W-1:0] resp_prog;
  logic [CNT_W-1:0]  resp_cycles;
  logic              resp_timeout;
  logic              resp_abort;
  logic [PROG_W-1:0] prog_sel;
  logic              core_reset;
  logic              core_start;
  logic              core_ack;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  prog_run_ctrl #(
    .PROG_W(PROG_W), .CNT_W(CNT_W), .RST_CYCLES(2), .START_CYCLES(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_prog(req_prog),
    .abort(abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_prog(resp_prog),
    .resp_cycles(resp_cycles), .resp_timeout(resp_timeout), .resp_abort(resp_abort),
    .prog_sel(prog_sel), .core_reset(core_reset), .core_start(core_start),
    .core_ack(core_ack), .busy(busy)
  );

  // 10 ns clock
  always #5 Clk = ~Clk;

  // abort_stage: 0 none, 1 first RESET cycle, 2 START, 3 RUN cycle abort_run
  typedef struct {
    logic [1:0] prog;
    int         ack_run;
    int         abort_stage;
    int         abort_run;
    bit         stale;
    bit         chk_cycles;
    int         exp_cycles;
    bit         exp_to;
    bit         exp_ab;
    int         exp_exit;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_one(input vec_t v);
    int k;
    req_valid = 1'b1;
    req_prog  = v.prog;
    core_ack  = v.stale;
    check("idle_req_ready", int'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    check("reset1_core_reset", int'(core_reset), 1);
    check("reset1_busy", int'(busy), 1);
    check("reset1_req_ready", int'(req_ready), 0);
    check("reset1_prog_sel", int'(prog_sel), int'(v.prog));
    if (v.abort_stage == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end else begin
      tick();
      check("reset2_core_reset", int'(core_reset), 1);
      check("reset2_core_start", int'(core_start), 0);
      tick();
      check("start_core_start", int'(core_start), 1);
      check("start_core_reset", int'(core_reset), 0);
      if (v.abort_stage == 2) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else begin
        tick();
        check("run0_core_start", int'(core_start), 0);
        check("run0_resp_valid", int'(resp_valid), 0);
        k = 0;
        while (!resp_valid && k < TIMEOUT + 5) begin
          core_ack = v.stale || (k == v.ack_run);
          abort    = (v.abort_stage == 3) && (k == v.abort_run);
          tick();
          k++;
        end
        abort = 1'b0;
        check("run_exit_cycle", k - 1, v.exp_exit);
      end
    end
    core_ack = 1'b0;
    check("resp_valid", int'(resp_valid), 1);
    check("resp_prog", int'(resp_prog), int'(v.prog));
    check("resp_timeout", int'(resp_timeout), int'(v.exp_to));
    check("resp_abort", int'(resp_abort), int'(v.exp_ab));
    if (v.chk_cycles) check("resp_cycles", int'(resp_cycles), v.exp_cycles);
    check("resp_core_reset", int'(core_reset), 0);
    check("resp_prog_sel", int'(prog_sel), int'(v.prog));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("post_resp_valid", int'(resp_valid), 0);
    check("post_busy", int'(busy), 0);
    check("post_resp_prog_hold", int'(resp_prog), int'(v.prog));
  endtask

  // Drives a request and steps to the first RUN cycle without checking
  task automatic start_run(input logic [1:0] p);
    req_valid = 1'b1;
    req_prog  = p;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Main sequence
  initial begin
    //          prog ack  stg arun stale chk cyc to ab exit
    vecs[0] = '{2'd2, 10, 0, -1, 1'b0, 1'b1, 10, 1'b0, 1'b0, 10};
    vecs[1] = '{2'd1,  0, 0, -1, 1'b0, 1'b1,  0, 1'b0, 1'b0,  0};
    vecs[2] = '{2'd3, -1, 0, -1, 1'b0, 1'b1, 50, 1'b1, 1'b0, 50};
    vecs[3] = '{2'd0, 50, 0, -1, 1'b0, 1'b1, 50, 1'b0, 1'b0, 50};
    vecs[4] = '{2'd1,  5, 3,  5, 1'b0, 1'b0,  0, 1'b0, 1'b1,  5};
    vecs[5] = '{2'd2, -1, 1, -1, 1'b0, 1'b1,  0, 1'b0, 1'b1,  0};
    vecs[6] = '{2'd3, -1, 2, -1, 1'b0, 1'b1,  0, 1'b0, 1'b1,  0};
    vecs[7] = '{2'd2, -1, 0, -1, 1'b1, 1'b1,  0, 1'b0, 1'b0,  0};
    vecs[8] = '{2'd0, 49, 0, -1, 1'b0, 1'b1, 49, 1'b0, 1'b0, 49};

    Reset = 1'b0; req_valid = 1'b0; req_prog = '0; abort = 1'b0;
    resp_ready = 1'b0; core_ack = 1'b0;
    tick(); tick(); tick();
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_core_start", int'(core_start), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_cycles", int'(resp_cycles), 0);
    check("rst_resp_timeout", int'(resp_timeout), 0);
    check("rst_resp_abort", int'(resp_abort), 0);
    check("rst_resp_prog", int'(resp_prog), 0);
    check("rst_prog_sel", int'(prog_sel), 0);
    check("rst_busy", int'(busy), 0);
    Reset = 1'b1;
    tick();

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_ignored", int'(busy), 0);

    for (int i = 0; i < 9; i++) run_one(vecs[i]);

    // Backpressure: result held while the host stalls, request waits one IDLE cycle
    start_run(2'd1);
    tick(); tick(); tick();
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    check("bp_resp_cycles", int'(resp_cycles), 3);
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1;
      req_prog  = 2'd2;
      check("bp_resp_valid", int'(resp_valid), 1);
      check("bp_cycles_stable", int'(resp_cycles), 3);
      check("bp_prog_stable", int'(resp_prog), 1);
      check("bp_prog_sel", int'(prog_sel), 1);
      check("bp_req_ready", int'(req_ready), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_gap_busy", int'(busy), 0);
    check("bp_gap_req_ready", int'(req_ready), 1);
    check("bp_gap_resp_valid", int'(resp_valid), 0);
    tick();
    req_valid = 1'b0;
    check("bp_accept_busy", int'(busy), 1);
    check("bp_accept_prog_sel", int'(prog_sel), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("bp_abort_flag", int'(resp_abort), 1);
    check("bp_abort_cycles", int'(resp_cycles), 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset in the middle of RUN
    start_run(2'd3);
    for (int i = 0; i < 7; i++) tick();
    Reset = 1'b0;
    tick();
    check("midrst_core_reset", int'(core_reset), 1);
    check("midrst_resp_valid", int'(resp_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_prog_sel", int'(prog_sel), 0);
    Reset = 1'b1;
    tick();
    run_one(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
